// File: rtl/steer_pkg.sv
// Shared types and widths for the steering command scheduler.
package steer_pkg;
  localparam int ANGLE_W   = 12;
  localparam int TIMEOUT_W = 24;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ABORT = 3'd3,
    ST_DONE  = 3'd4
  } state_e;
endpackage

// File: rtl/steer_ch_tracker.sv
// Per-channel tracker: pending/issued state, startup_fail retry sequencing,
// and the channel's own angle_update / abort_angle pulses.
module steer_ch_tracker
  import steer_pkg::*;
#(
  parameter int MAX_RETRY = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic mask_i,
  input  logic issue_i,
  input  logic track_en_i,
  input  logic abort_now_i,
  input  logic clr_pend_i,
  input  logic angle_done_i,
  input  logic startup_fail_i,
  output logic pending_o,
  output logic issued_o,
  output logic done_o,
  output logic fail_o,
  output logic angle_update_o,
  output logic abort_angle_o
);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic          pending_q, pending_d, issued_q, issued_d;
  logic          done_q, done_d, fail_q, fail_d;
  logic          upd_q, upd_d, abt_q, abt_d;
  logic          retry_upd_q, retry_upd_d, sf_prev_q;
  logic [RW-1:0] retry_q, retry_d;
  logic          sf_rise;

  assign sf_rise = startup_fail_i & ~sf_prev_q;

  // Next-state for tracking, retry and the per-channel pulses
  always_comb begin
    pending_d   = pending_q;
    issued_d    = issued_q;
    done_d      = done_q;
    fail_d      = fail_q;
    retry_d     = retry_q;
    upd_d       = 1'b0;
    abt_d       = 1'b0;
    retry_upd_d = 1'b0;
    if (clear_i) begin
      pending_d = mask_i;
      issued_d  = 1'b0;
      done_d    = 1'b0;
      fail_d    = 1'b0;
      retry_d   = '0;
    end else begin
      if (issue_i) begin
        upd_d    = 1'b1;
        issued_d = 1'b1;
      end else if (retry_upd_q && !abort_now_i) begin
        upd_d = 1'b1;
      end else begin
        upd_d = 1'b0;
      end
      // done beats a same-cycle startup_fail edge
      if (track_en_i && pending_q && issued_q) begin
        if (angle_done_i) begin
          pending_d = 1'b0;
          done_d    = 1'b1;
        end else if (sf_rise) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            abt_d       = 1'b1;
            retry_upd_d = 1'b1;
            retry_d     = retry_q + RW'(1);
          end else begin
            pending_d = 1'b0;
            fail_d    = 1'b1;
          end
        end else begin
          retry_upd_d = 1'b0;
        end
      end else begin
        retry_upd_d = 1'b0;
      end
      if (abort_now_i) begin
        abt_d       = abt_d | (pending_q & issued_q);
        retry_upd_d = 1'b0;
      end else begin
        abt_d = abt_d;
      end
      if (clr_pend_i) begin
        pending_d = 1'b0;
      end else begin
        pending_d = pending_d;
      end
    end
  end

  // Tracker registers
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q   <= 1'b0;
      issued_q    <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      retry_q     <= '0;
      upd_q       <= 1'b0;
      abt_q       <= 1'b0;
      retry_upd_q <= 1'b0;
      sf_prev_q   <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      issued_q    <= issued_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      retry_q     <= retry_d;
      upd_q       <= upd_d;
      abt_q       <= abt_d;
      retry_upd_q <= retry_upd_d;
      sf_prev_q   <= startup_fail_i;
    end
  end

  assign pending_o      = pending_q;
  assign issued_o       = issued_q;
  assign done_o         = done_q;
  assign fail_o         = fail_q;
  assign angle_update_o = upd_q;
  assign abort_angle_o  = abt_q;
endmodule

// File: rtl/steer_cmd_scheduler.sv
// Multi-wheel steering command scheduler: staggered issue, completion
// tracking, global timeout and abort handling.
module steer_cmd_scheduler
  import steer_pkg::*;
#(
  parameter int                   NUM_CH         = 4,
  parameter int                   STAGGER_CYCLES = 8,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 24'd5000000,
  parameter int                   MAX_RETRY      = 2,
  parameter int                   ABORT_HOLD     = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      pwm_enable,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [NUM_CH-1:0]         cmd_mask,
  input  logic [ANGLE_W*NUM_CH-1:0] cmd_angles,
  input  logic                      abort_req,
  output logic [ANGLE_W*NUM_CH-1:0] target_angle,
  output logic [NUM_CH-1:0]         angle_update,
  output logic [NUM_CH-1:0]         abort_angle,
  input  logic [NUM_CH-1:0]         angle_done,
  input  logic [NUM_CH-1:0]         startup_fail,
  output logic                      busy,
  output logic                      cmd_done,
  output logic [NUM_CH-1:0]         done_mask,
  output logic [NUM_CH-1:0]         fail_mask,
  output logic [NUM_CH-1:0]         timeout_mask,
  output logic                      aborted
);
  localparam int SW = (STAGGER_CYCLES > 0) ? $clog2(STAGGER_CYCLES + 1) : 1;
  localparam int HW = $clog2(ABORT_HOLD + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(ABORT_HOLD - 1);

  state_e                      state_q, state_d;
  logic [SW-1:0]               stag_q, stag_d;
  logic [TIMEOUT_W-1:0]        tmo_q, tmo_d, tmo_inc;
  logic [HW-1:0]               hold_q, hold_d;
  logic [ANGLE_W*NUM_CH-1:0]   target_q, target_d;
  logic [NUM_CH-1:0]           tmo_mask_q, tmo_mask_d;
  logic                        aborted_q, aborted_d;
  logic                        busy_q, busy_d, cmd_ready_q, cmd_ready_d, cmd_done_q, cmd_done_d;
  logic [NUM_CH-1:0]           pending, issued, to_issue, lowest, issue_sel;
  logic                        clear_s, clr_pend_s, track_en_s, abort_now_s, stop_req;

  assign to_issue = pending & ~issued;
  assign lowest   = to_issue & (~to_issue + NUM_CH'(1));
  assign tmo_inc  = (tmo_q == {TIMEOUT_W{1'b1}}) ? tmo_q : tmo_q + TIMEOUT_W'(1);
  assign stop_req = abort_req | ~pwm_enable;

  // Command FSM with stagger, timeout and abort-hold counters
  always_comb begin
    state_d    = state_q;
    stag_d     = stag_q;
    tmo_d      = tmo_q;
    hold_d     = hold_q;
    target_d   = target_q;
    tmo_mask_d = tmo_mask_q;
    aborted_d  = aborted_q;
    issue_sel  = '0;
    clear_s    = 1'b0;
    clr_pend_s = 1'b0;
    track_en_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          target_d   = cmd_angles;
          tmo_mask_d = '0;
          aborted_d  = 1'b0;
          tmo_d      = '0;
          stag_d     = '0;
          clear_s    = 1'b1;
          state_d    = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE, ST_WAIT: begin
        tmo_d = tmo_inc;
        // abort outranks timeout, which outranks completion tracking
        if (stop_req) begin
          state_d   = ST_ABORT;
          aborted_d = 1'b1;
          hold_d    = HOLD_INIT;
        end else if ((tmo_inc == TIMEOUT_CYCLES) && (pending != '0)) begin
          state_d    = ST_ABORT;
          tmo_mask_d = pending;
          hold_d     = HOLD_INIT;
        end else begin
          track_en_s = 1'b1;
          if (state_q == ST_WAIT) begin
            if (pending == '0) state_d = ST_DONE;
            else               state_d = ST_WAIT;
          end else if (stag_q != '0) begin
            stag_d = stag_q - SW'(1);
          end else if (to_issue != '0) begin
            issue_sel = lowest;
            stag_d    = SW'(STAGGER_CYCLES);
            if ((to_issue & ~lowest) == '0) state_d = ST_WAIT;
            else                            state_d = ST_ISSUE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_ABORT: begin
        if (hold_q == '0) begin
          state_d    = ST_DONE;
          clr_pend_s = 1'b1;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign abort_now_s = (state_d == ST_ABORT);
  assign busy_d      = (state_d != ST_IDLE);
  assign cmd_ready_d = (state_d == ST_IDLE);
  assign cmd_done_d  = (state_d == ST_DONE);

  // Control and status registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      stag_q      <= '0;
      tmo_q       <= '0;
      hold_q      <= '0;
      target_q    <= '0;
      tmo_mask_q  <= '0;
      aborted_q   <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      cmd_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      stag_q      <= stag_d;
      tmo_q       <= tmo_d;
      hold_q      <= hold_d;
      target_q    <= target_d;
      tmo_mask_q  <= tmo_mask_d;
      aborted_q   <= aborted_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
      cmd_done_q  <= cmd_done_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    steer_ch_tracker #(.MAX_RETRY(MAX_RETRY)) u_trk (
      .clock          (clock),
      .reset          (reset),
      .clear_i        (clear_s),
      .mask_i         (cmd_mask[i]),
      .issue_i        (issue_sel[i]),
      .track_en_i     (track_en_s),
      .abort_now_i    (abort_now_s),
      .clr_pend_i     (clr_pend_s),
      .angle_done_i   (angle_done[i]),
      .startup_fail_i (startup_fail[i]),
      .pending_o      (pending[i]),
      .issued_o       (issued[i]),
      .done_o         (done_mask[i]),
      .fail_o         (fail_mask[i]),
      .angle_update_o (angle_update[i]),
      .abort_angle_o  (abort_angle[i])
    );
  end

  assign cmd_ready    = cmd_ready_q;
  assign busy         = busy_q;
  assign cmd_done     = cmd_done_q;
  assign aborted      = aborted_q;
  assign timeout_mask = tmo_mask_q;
  assign target_angle = target_q;
endmodule

// File: tb/tb_steer_cmd_scheduler.sv
// Directed bench for steer_cmd_scheduler (stagger 4, timeout 100, retry 2, hold 4).
module tb_steer_cmd_scheduler;
  logic        clock = 1'b0;
  logic        reset, pwm_enable, cmd_valid, abort_req;
  logic        cmd_ready, busy, cmd_done, aborted;
  logic [3:0]  cmd_mask, angle_update, abort_angle, angle_done, startup_fail;
  logic [3:0]  done_mask, fail_mask, timeout_mask;
  logic [47:0] cmd_angles, target_angle;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clock = ~clock;

  steer_cmd_scheduler #(
    .NUM_CH(4), .STAGGER_CYCLES(4), .TIMEOUT_CYCLES(24'd100),
    .MAX_RETRY(2), .ABORT_HOLD(4)
  ) dut (
    .clock(clock), .reset(reset), .pwm_enable(pwm_enable),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mask(cmd_mask),
    .cmd_angles(cmd_angles), .abort_req(abort_req), .target_angle(target_angle),
    .angle_update(angle_update), .abort_angle(abort_angle), .angle_done(angle_done),
    .startup_fail(startup_fail), .busy(busy), .cmd_done(cmd_done),
    .done_mask(done_mask), .fail_mask(fail_mask), .timeout_mask(timeout_mask),
    .aborted(aborted)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Handshake; returns just after the accepting edge T
  task automatic accept(input logic [3:0] m, input logic [47:0] a);
    cmd_mask   = m;
    cmd_angles = a;
    cmd_valid  = 1'b1;
    tick();
    cmd_valid  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; pwm_enable = 1'b1; cmd_valid = 1'b0; abort_req = 1'b0;
    cmd_mask = 4'h0; cmd_angles = 48'h0; angle_done = 4'h0; startup_fail = 4'h0;
    tick(); tick();
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_ready: got %b expected 1", cmd_ready);
    end
    vectors++;
    if ({busy, cmd_done, aborted, angle_update, abort_angle, done_mask, fail_mask, timeout_mask, target_angle} !== 71'd0) begin
      miscompares++; $display("FAIL reset_outputs: got busy=%b done=%b upd=%b abt=%b tgt=%h expected all 0",
                              busy, cmd_done, angle_update, abort_angle, target_angle);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_stagger();
    logic [3:0] e;
    logic       ed;
    accept(4'hF, 48'hABC_789_456_123);
    vectors++;
    if (target_angle !== 48'hABC_789_456_123) begin
      miscompares++; $display("FAIL stagger_target: got %h expected abc789456123", target_angle);
    end
    for (int k = 1; k <= 21; k++) begin
      tick();
      e  = (k == 1) ? 4'b0001 : (k == 6) ? 4'b0010 : (k == 11) ? 4'b0100 : (k == 16) ? 4'b1000 : 4'b0000;
      ed = (k == 20);
      vectors++;
      if (angle_update !== e) begin
        miscompares++; $display("FAIL stagger_upd T+%0d: got %b expected %b", k, angle_update, e);
      end
      vectors++;
      if (cmd_done !== ed) begin
        miscompares++; $display("FAIL stagger_cmd_done T+%0d: got %b expected %b", k, cmd_done, ed);
      end
      if (k == 1) begin
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++; $display("FAIL stagger_busy: got %b expected 1", busy);
        end
      end
      angle_done = (k == 3) ? 4'b0001 : (k == 8) ? 4'b0010 : (k == 13) ? 4'b0100 : (k == 18) ? 4'b1000 : 4'b0000;
    end
    vectors++;
    if ({done_mask, cmd_ready, busy} !== 6'b1111_1_0) begin
      miscompares++; $display("FAIL stagger_final: got done_mask=%b ready=%b busy=%b expected 1111 1 0", done_mask, cmd_ready, busy);
    end
  endtask

  task automatic test_empty_mask();
    logic ed, er;
    accept(4'h0, 48'h111_222_333_444);
    for (int k = 1; k <= 3; k++) begin
      tick();
      ed = (k == 2);
      er = (k == 3);
      vectors++;
      if ({angle_update, cmd_done, cmd_ready} !== {4'b0000, ed, er}) begin
        miscompares++; $display("FAIL empty_seq T+%0d: got upd=%b done=%b ready=%b expected 0000 %b %b",
                                k, angle_update, cmd_done, cmd_ready, ed, er);
      end
    end
    vectors++;
    if ({done_mask, fail_mask, timeout_mask, aborted} !== 13'd0) begin
      miscompares++; $display("FAIL empty_masks: got %b %b %b %b expected all 0", done_mask, fail_mask, timeout_mask, aborted);
    end
  endtask

  task automatic test_retry();
    logic [3:0] eu, ea;
    logic       ed;
    accept(4'hF, 48'h0FF_0AA_055_000);
    for (int k = 1; k <= 29; k++) begin
      tick();
      eu = (k == 1) ? 4'b0001 : (k == 6) ? 4'b0010 : (k == 11 || k == 14 || k == 22) ? 4'b0100 :
           (k == 16) ? 4'b1000 : 4'b0000;
      ea = (k == 13 || k == 21) ? 4'b0100 : 4'b0000;
      ed = (k == 28);
      vectors++;
      if (angle_update !== eu) begin
        miscompares++; $display("FAIL retry_upd T+%0d: got %b expected %b", k, angle_update, eu);
      end
      vectors++;
      if (abort_angle !== ea) begin
        miscompares++; $display("FAIL retry_abt T+%0d: got %b expected %b", k, abort_angle, ea);
      end
      vectors++;
      if (cmd_done !== ed) begin
        miscompares++; $display("FAIL retry_cmd_done T+%0d: got %b expected %b", k, cmd_done, ed);
      end
      angle_done   = (k == 3) ? 4'b0001 : (k == 8) ? 4'b0010 : (k == 18) ? 4'b1000 : 4'b0000;
      startup_fail = ((k >= 12 && k < 14) || (k >= 20 && k < 22) || (k >= 26 && k < 28)) ? 4'b0100 : 4'b0000;
    end
    vectors++;
    if ({fail_mask, done_mask, timeout_mask, aborted} !== {4'b0100, 4'b1011, 4'b0000, 1'b0}) begin
      miscompares++; $display("FAIL retry_masks: got fail=%b done=%b tmo=%b ab=%b expected 0100 1011 0000 0",
                              fail_mask, done_mask, timeout_mask, aborted);
    end
  endtask

  task automatic test_timeout();
    logic [3:0] ea;
    logic       ed;
    accept(4'hF, 48'h800_800_800_800);
    for (int k = 1; k <= 105; k++) begin
      tick();
      ea = (k >= 100 && k <= 103) ? 4'b0010 : 4'b0000;
      ed = (k == 104);
      vectors++;
      if (abort_angle !== ea) begin
        miscompares++; $display("FAIL timeout_abt T+%0d: got %b expected %b", k, abort_angle, ea);
      end
      vectors++;
      if (cmd_done !== ed) begin
        miscompares++; $display("FAIL timeout_cmd_done T+%0d: got %b expected %b", k, cmd_done, ed);
      end
      angle_done = (k == 3) ? 4'b0001 : (k == 13) ? 4'b0100 : (k == 18) ? 4'b1000 : 4'b0000;
    end
    vectors++;
    if ({timeout_mask, done_mask, fail_mask, aborted, cmd_ready} !== {4'b0010, 4'b1101, 4'b0000, 1'b0, 1'b1}) begin
      miscompares++; $display("FAIL timeout_masks: got tmo=%b done=%b fail=%b ab=%b rdy=%b expected 0010 1101 0000 0 1",
                              timeout_mask, done_mask, fail_mask, aborted, cmd_ready);
    end
  endtask

  task automatic test_abort();
    logic [3:0] eu, ea;
    logic       ed;
    accept(4'hF, 48'h001_002_003_004);
    for (int k = 1; k <= 8; k++) begin
      tick();
      eu = (k == 1) ? 4'b0001 : 4'b0000;
      ea = (k >= 3 && k <= 6) ? 4'b0001 : 4'b0000;
      ed = (k == 7);
      vectors++;
      if ({angle_update, abort_angle, cmd_done} !== {eu, ea, ed}) begin
        miscompares++; $display("FAIL abort_seq T+%0d: got upd=%b abt=%b done=%b expected %b %b %b",
                                k, angle_update, abort_angle, cmd_done, eu, ea, ed);
      end
      abort_req = (k == 2);
    end
    vectors++;
    if ({aborted, done_mask, timeout_mask, fail_mask, cmd_ready} !== {1'b1, 12'd0, 1'b1}) begin
      miscompares++; $display("FAIL abort_status: got ab=%b done=%b tmo=%b fail=%b rdy=%b expected 1 0000 0000 0000 1",
                              aborted, done_mask, timeout_mask, fail_mask, cmd_ready);
    end
  endtask

  task automatic test_reset_in_wait();
    accept(4'hF, 48'hFFF_EEE_DDD_CCC);
    for (int k = 1; k <= 17; k++) begin
      tick();
      startup_fail = (k >= 16) ? 4'b0001 : 4'b0000;
    end
    vectors++;
    if (abort_angle !== 4'b0001) begin
      miscompares++; $display("FAIL rst_wait_retry_abt: got %b expected 0001", abort_angle);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    startup_fail = 4'b0000;
    vectors++;
    if ({angle_update, abort_angle, busy, cmd_done, done_mask, fail_mask, timeout_mask, aborted, target_angle} !== 64'd0) begin
      miscompares++; $display("FAIL rst_wait_outputs: got upd=%b abt=%b busy=%b done=%b tgt=%h expected all 0",
                              angle_update, abort_angle, busy, cmd_done, target_angle);
    end
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL rst_wait_ready: got %b expected 1", cmd_ready);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if ({cmd_done, cmd_ready, angle_update} !== 6'b0_1_0000) begin
        miscompares++; $display("FAIL rst_wait_quiet +%0d: got done=%b rdy=%b upd=%b expected 0 1 0000",
                                k, cmd_done, cmd_ready, angle_update);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stagger();
    test_empty_mask();
    test_retry();
    test_timeout();
    test_abort();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
